// File: rtl/rca_pipe_adder_pkg.sv
// Shared sizing for the pipelined ripple-carry adder/subtractor.
// Default geometry and the stage-count derivation live here.
package rca_pipe_adder_pkg;

  localparam int RCA_WIDTH = 16;
  localparam int RCA_CHUNK = 4;

  function automatic int rca_nstages(input int w, input int c);
    return w / c;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the ripple cell of rca_chunk.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple segment built from full adders.
// c_msb_in exposes the carry entering the top bit for overflow.
module rca_chunk
  import rca_pipe_adder_pkg::*;
#(
  parameter int CHUNK = RCA_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic w_ci;
    logic w_co;
    if (i == 0) begin : g_c
      assign w_ci = cin;
    end else begin : g_c
      assign w_ci = g_bit[i-1].w_co;
    end
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_ci),
      .s   (s[i]),
      .cout(w_co)
    );
  end

  assign cout     = g_bit[CHUNK-1].w_co;
  assign c_msb_in = g_bit[CHUNK-1].w_ci;

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK per stage,
// with a valid/ready chain that fills behind a downstream stall.
module rca_pipe_adder
  import rca_pipe_adder_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CHUNK = RCA_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSTAGES = rca_nstages(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_chk
    $fatal(1, "rca_pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [WIDTH-1:0]   w_bx;
  logic [NSTAGES-1:0] w_v;
  logic [NSTAGES:0]   w_adv;

  assign w_bx = b ^ {WIDTH{sub}};

  // A stage may load when empty or when the stage after it moves.
  always_comb begin
    w_adv          = '0;
    w_adv[NSTAGES] = out_ready;
    for (int k = NSTAGES - 1; k >= 0; k--)
      w_adv[k] = !w_v[k] || w_adv[k+1];
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_s;
    logic             w_cin;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_vin;
    logic [HI-1:0]    w_sum_nx;
    logic [HI-1:0]    r_sum;
    logic             r_c;
    logic             r_v;

    if (k == 0) begin : g_in
      assign w_vin    = in_valid;
      assign w_ca     = a[CHUNK-1:0];
      assign w_cb     = w_bx[CHUNK-1:0];
      assign w_cin    = carry_in ^ sub;
      assign w_sum_nx = w_s;
    end else begin : g_in
      assign w_vin    = g_st[k-1].r_v;
      assign w_ca     = g_st[k-1].g_sk.r_a[CHUNK-1:0];
      assign w_cb     = g_st[k-1].g_sk.r_b[CHUNK-1:0];
      assign w_cin    = g_st[k-1].r_c;
      assign w_sum_nx = {w_s, g_st[k-1].r_sum};
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (w_ca),
      .b       (w_cb),
      .cin     (w_cin),
      .s       (w_s),
      .cout    (w_cout),
      .c_msb_in(w_cmsb)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_adv[k]) begin
        r_v   <= w_vin;
        r_sum <= w_sum_nx;
        r_c   <= w_cout;
      end
    end

    assign w_v[k] = r_v;

    // Operand bits not yet consumed ride along with the partial sum.
    if (k < NSTAGES - 1) begin : g_sk
      logic [WIDTH-HI-1:0] w_a_nx;
      logic [WIDTH-HI-1:0] w_b_nx;
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;

      if (k == 0) begin : g_src
        assign w_a_nx = a[WIDTH-1:HI];
        assign w_b_nx = w_bx[WIDTH-1:HI];
      end else begin : g_src
        assign w_a_nx = g_st[k-1].g_sk.r_a[WIDTH-LO-1:CHUNK];
        assign w_b_nx = g_st[k-1].g_sk.r_b[WIDTH-LO-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv[k]) begin
          r_a <= w_a_nx;
          r_b <= w_b_nx;
        end
      end
    end

    if (k == NSTAGES - 1) begin : g_ov
      logic r_ovf;
      always_ff @(posedge clk) begin
        if (!rst_n)        r_ovf <= 1'b0;
        else if (w_adv[k]) r_ovf <= w_cmsb ^ w_cout;
      end
    end else begin : g_nov
      logic w_unused_cmsb;
      assign w_unused_cmsb = w_cmsb;
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[NSTAGES-1];
  assign sum       = g_st[NSTAGES-1].r_sum;
  assign carry_out = g_st[NSTAGES-1].r_c;
  assign overflow  = g_st[NSTAGES-1].g_ov.r_ovf;

endmodule
